// File: rtl/mdu_e_if.sv
// Issue/result bundle between the E-stage pipeline and the multiply/divide unit.
// The pipeline (master) issues operations; the unit (slave) reports busy and HI/LO.
interface mdu_e_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, md_op, a, b, input  busy, hi, lo);
   modport slave  (input  start, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_e.sv
// Multiply/divide unit with architectural HI/LO. Results are computed at issue
// and held back until a latency down-counter expires, modelling a multi-cycle unit.
//
//   state  | meaning
//   S_IDLE | accepting mult/div/mthi/mtlo; busy low
//   S_RUN  | result latched, counting down; commits to HI/LO when count hits 1
module mdu_e #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic   clk,
   input  logic   reset,
   mdu_e_if.slave mdu
);
   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             dz_q, dz_d;

   logic               is_signed;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod, res;

   // One magnitude divider serves both div and divu; signs are restored afterwards
   always_comb begin
      is_signed = (mdu.md_op == 3'd0) || (mdu.md_op == 3'd2);
      a_neg     = is_signed & mdu.a[WIDTH-1];
      b_neg     = is_signed & mdu.b[WIDTH-1];
      a_ext     = {{WIDTH{a_neg}}, mdu.a};
      b_ext     = {{WIDTH{b_neg}}, mdu.b};
      prod      = a_ext * b_ext;
      a_mag     = a_neg ? -mdu.a : mdu.a;
      b_mag     = b_neg ? -mdu.b : mdu.b;
      q_mag     = (b_mag == '0) ? '0 : a_mag / b_mag;
      r_mag     = (b_mag == '0) ? '0 : a_mag % b_mag;
      quo       = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem       = a_neg ? -r_mag : r_mag;
      res       = mdu.md_op[1] ? {rem, quo} : prod;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      dz_d     = dz_q;
      case (state_q)
         S_IDLE: begin
            if (mdu.start) begin
               case (mdu.md_op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     res_hi_d = res[2*WIDTH-1:WIDTH];
                     res_lo_d = res[WIDTH-1:0];
                     dz_d     = mdu.md_op[1] && (mdu.b == '0);
                     cnt_d    = mdu.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                     state_d  = S_RUN;
                  end
                  3'd4:    hi_d = mdu.a;
                  3'd5:    lo_d = mdu.a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               // divide by zero burns the window but leaves HI/LO alone
               if (!dz_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         dz_q     <= dz_d;
      end
   end

   assign mdu.busy = (state_q == S_RUN);
   assign mdu.hi   = hi_q;
   assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_mdu_e.sv
// Bench for mdu_e: fixed vector table, randomized ops against an arithmetic
// reference model, and hand sequences for ignored start and reset abort.
module tb_mdu_e;
   logic clk;
   logic reset;

   mdu_e_if #(.WIDTH(32)) bus ();

   mdu_e #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; C-style truncating division matches MIPS.
   function automatic int model(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, inout logic [31:0] h,
                                inout logic [31:0] l);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; return 5; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; return 5; end
         3'd2: begin
            if (b != 0) begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            return 10;
         end
         3'd3: begin
            if (b != 0) begin l = a / b; h = a % b; end
            return 10;
         end
         3'd4: begin h = a; return 0; end
         3'd5: begin l = a; return 0; end
         default: return 0;
      endcase
   endfunction

   // Issue at the next edge, then count busy cycles; returns with the first idle cycle sampled.
   task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int nbusy, output bit early);
      logic [31:0] ph, pl;
      bus.start = 1'b1;
      bus.md_op = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      ph = bus.hi;
      pl = bus.lo;
      nbusy = 0;
      early = 1'b0;
      while (bus.busy && nbusy < 60) begin
         if (bus.hi !== ph || bus.lo !== pl) early = 1'b1;
         nbusy++;
         @(negedge clk);
      end
   endtask

   initial begin
      int  nb;
      bit  early;
      int  lat;
      logic [2:0]  op;
      logic [31:0] ra, rb;
      logic [31:0] eh, el;

      tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
      tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
      tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      tbl[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      tbl[4] = '{3'd4, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h8000_0000, 0};
      tbl[5] = '{3'd5, 32'h0000_5678, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 0};
      tbl[6] = '{3'd3, 32'h0000_9999, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 10};
      tbl[7] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
      tbl[8] = '{3'd6, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_000E, 0};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.md_op = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_hi", bus.hi, 32'd0);
      chk("reset_lo", bus.lo, 32'd0);

      for (int i = 0; i < 9; i++) begin
         drive_op(tbl[i].op, tbl[i].a, tbl[i].b, nb, early);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(tbl[i].lat));
         chk($sformatf("vec%0d_hi", i), bus.hi, tbl[i].hi);
         chk($sformatf("vec%0d_lo", i), bus.lo, tbl[i].lo);
         chk($sformatf("vec%0d_no_early_commit", i), {31'd0, early}, 32'd0);
      end
      m_hi = 32'h0000_0002;
      m_lo = 32'h0000_000E;

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            3: rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         eh  = m_hi;
         el  = m_lo;
         lat = model(op, ra, rb, eh, el);
         drive_op(op, ra, rb, nb, early);
         chk($sformatf("rnd%0d_op%0d_busy_cycles", i, op), 32'(nb), 32'(lat));
         chk($sformatf("rnd%0d_op%0d_hi", i, op), bus.hi, eh);
         chk($sformatf("rnd%0d_op%0d_lo", i, op), bus.lo, el);
         if (lat != 0)
            chk($sformatf("rnd%0d_no_early_commit", i), {31'd0, early}, 32'd0);
         m_hi = eh;
         m_lo = el;
      end

      // mtlo issued in the second busy cycle of a mult must be dropped
      bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'd3; bus.b = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      nb = bus.busy ? 1 : 0;
      @(negedge clk);
      bus.start = 1'b1; bus.md_op = 3'd5; bus.a = 32'h0000_DEAD;
      if (bus.busy) nb++;
      @(negedge clk);
      bus.start = 1'b0;
      while (bus.busy && nb < 60) begin
         nb++;
         @(negedge clk);
      end
      chk("ignored_start_busy_cycles", 32'(nb), 32'd5);
      chk("ignored_start_hi", bus.hi, 32'd0);
      chk("ignored_start_lo", bus.lo, 32'd12);

      // reset in the third busy cycle aborts the mult; a same-cycle start is ignored
      drive_op(3'd4, 32'h0000_0077, 32'd0, nb, early);
      chk("pre_abort_hi", bus.hi, 32'h0000_0077);
      bus.start = 1'b1; bus.md_op = 3'd0; bus.a = 32'd3; bus.b = 32'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_busy_before_reset", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      bus.start = 1'b1; bus.md_op = 3'd1; bus.a = 32'd7; bus.b = 32'd7;
      @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b0;
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_hi", bus.hi, 32'd0);
      chk("abort_lo", bus.lo, 32'd0);
      early = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.busy || bus.hi !== 32'd0 || bus.lo !== 32'd0) early = 1'b1;
      end
      chk("abort_no_late_commit", {31'd0, early}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mdu_e.md
# mdu_e

Execute-stage multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the E stage of the five-stage MIPS pipeline. It accepts one operation per issue, models multi-cycle latency with a counter-driven busy window, and exposes HI/LO for `mfhi`/`mflo` forwarding. The D-stage hazard unit stalls any HI/LO-touching instruction while `start | busy` is high. Operand width and operation latencies are parameters.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `MULT_CYCLES`, 5, busy cycles for `mult`/`multu`; must be ≥1.
- `DIV_CYCLES`, 10, busy cycles for `div`/`divu`; must be ≥1.

- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start`  in  1  E-stage instruction is a valid, non-stalled MDU op this cycle.
- `md_op`  in  3  0 `mult`, 1 `multu`, 2 `div`, 3 `divu`, 4 `mthi`, 5 `mtlo`; 6–7 are no-ops.
- `a`  in  WIDTH  forwarded rs value.
- `b`  in  WIDTH  forwarded rt value.
- `busy`  out  1  a mult/div is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. The counter width is `$clog2(max(MULT_CYCLES, DIV_CYCLES)+1)`.
- **IDLE, `start` with `md_op` 0–3:**
  - Compute the 2·WIDTH result combinationally from `a` and `b`, and latch it into internal `res_hi`/`res_lo`.
  - Load the counter with the op's latency and go to RUN.
- **IDLE, `start` with `md_op` 4 or 5:** write `a` into HI or LO at that edge. No busy window.
- **RUN:**
  - Decrement the counter each cycle.
  - When the counter equals 1, commit `res_hi`→HI and `res_lo`→LO, then return to IDLE.
- **`start` while in RUN:** ignored; HI, LO, and the in-flight result are unaffected. The hazard unit guarantees this never occurs legally.
- **Multiply:**
  - Full 2·WIDTH product; HI gets the upper half and LO the lower half.
  - `mult` is signed × signed; `multu` is unsigned.
- **Divide:**
  - LO gets the quotient and HI the remainder.
  - Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - `div` of the most-negative value by −1 gives LO = most-negative and HI = 0 (wraps, no trap).
- **Divide by zero (`b`==0, `div` or `divu`):** runs the full busy window, then HI and LO are left unchanged (no commit).
- **Reset:** HI = 0, LO = 0, state IDLE, counter 0, `busy` = 0. An in-flight operation is aborted and its result discarded.

## Timing
- **`start` of a mult/div at edge *t*:**
  - `busy` is 1 in cycles *t*+1 … *t*+N, where N is the op latency.
  - HI/LO hold the new values from cycle *t*+N+1.
  - `busy` is 0 in cycle *t*+N+1.
- **`mthi`/`mtlo` at edge *t*:** the new HI/LO is visible in cycle *t*+1. `busy` stays 0.
- **Back-to-back issue:** a new `start` is legal in the first cycle `busy` = 0. No dead cycle is required.
- **`hi`/`lo` outputs:** these are register outputs only; there is no internal bypass. An `mfhi` must wait for the commit.
- **`reset` asserted in a RUN cycle:** `busy` is 0 and HI = LO = 0 from the next cycle. A `start` asserted in the same cycle as `reset` is ignored.

## Test plan
- **Signed multiply:** reset, then `mult` with a=0xFFFFFFFD (−3) and b=5. Required: `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF1.
- **Unsigned multiply:** `multu` with a=0xFFFFFFFF and b=2. Required: HI=0x00000001 and LO=0xFFFFFFFE after 5 busy cycles.
- **Signed divide:** `div` with a=0xFFFFFFF9 (−7) and b=2. Required: `busy` high 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- **Overflow case:** `div` with a=0x80000000 and b=0xFFFFFFFF. Required: LO=0x80000000 and HI=0.
- **Divide by zero after move-to:** `mthi` a=0x1234, then `mtlo` a=0x5678 on consecutive cycles, then `divu` with b=0.
  - HI=0x1234 and LO=0x5678 after the moves, with `busy` never raised by them.
  - After the `divu` busy window, HI and LO are still 0x1234/0x5678.
- **Ignored start and reset abort:**
  - `mult` 3×4, then assert `start` with `mtlo` a=0xDEAD in cycle 2 of busy. Required: `mtlo` ignored; final HI=0 and LO=12.
  - Second `mult` 3×4, then assert `reset` in its third busy cycle. Required: next cycle `busy`=0 and HI=LO=0, and no commit ever occurs.
